// File: rtl/seg7_time_display.sv
// seg7_time_display: 4-digit multiplexed HH:MM display with per-frame snapshot, serial BCD conversion and blinking colon
module seg7_time_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] minutes,
  input  logic [4:0] hours,
  input  logic [5:0] alarm_minutes,
  input  logic [4:0] alarm_hours,
  input  logic       show_alarm,
  input  logic       blank,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_DIV - 1);
  logic [RW-1:0] ref_q, ref_d;
  logic [BW-1:0] blink_q, blink_d;
  logic [1:0] idx_q, idx_d;
  logic phase_q, phase_d, snap_q, snap_d, busy_q, busy_d, sa_q, sa_d;
  logic inv_m_q, inv_m_d, inv_h_q, inv_h_d;
  logic [5:0] rem_m_q, rem_m_d;
  logic [4:0] rem_h_q, rem_h_d;
  logic [3:0] ten_m_q, ten_m_d, ten_h_q, ten_h_d;
  // {inv_h, inv_m, h_tens, h_ones, m_tens, m_ones}; only rewritten as a whole on conversion done
  logic [17:0] disp_q, disp_d;
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d, code;
  logic dp_q, dp_d;
  logic tick, wrap, done, off, dash, lz, sub_m, sub_h, bad_m, bad_h;
  logic [5:0] sel_m;
  logic [4:0] sel_h;
  logic [3:0] digit;
  assign tick  = ref_q == REF_MAX;
  assign wrap  = blink_q == BLK_MAX;
  assign sel_m = show_alarm ? alarm_minutes : minutes;
  assign sel_h = show_alarm ? alarm_hours : hours;
  assign bad_m = sel_m > 6'd59;
  assign bad_h = sel_h > 5'd23;
  assign sub_m = busy_q && rem_m_q >= 6'd10;
  assign sub_h = busy_q && rem_h_q >= 5'd10;
  assign done  = busy_q && !sub_m && !sub_h;
  assign off   = blank | tick;
  assign digit = disp_q[{idx_q, 2'b00} +: 4];
  assign dash  = idx_q[1] ? disp_q[17] : disp_q[16];
  assign lz    = idx_q == 2'd3 && disp_q[15:12] == 4'd0;
  always_comb begin
    case (digit)
      4'd0: code = 7'b1000000;
      4'd1: code = 7'b1111001;
      4'd2: code = 7'b0100100;
      4'd3: code = 7'b0110000;
      4'd4: code = 7'b0011001;
      4'd5: code = 7'b0010010;
      4'd6: code = 7'b0000010;
      4'd7: code = 7'b1111000;
      4'd8: code = 7'b0000000;
      4'd9: code = 7'b0010000;
      default: code = 7'b1111111;
    endcase
  end
  always_comb begin
    ref_d   = tick ? '0 : ref_q + RW'(1);
    idx_d   = tick ? idx_q + 2'd1 : idx_q;
    blink_d = wrap ? '0 : blink_q + BW'(1);
    phase_d = phase_q ^ wrap;
    snap_d  = tick && idx_q == 2'd3;
    sa_d    = snap_q ? show_alarm : sa_q;
    inv_m_d = snap_q ? bad_m : inv_m_q;
    inv_h_d = snap_q ? bad_h : inv_h_q;
    busy_d  = snap_q | (busy_q & ~done);
    // an invalid pair converts as 0 so the worst case stays at 59 -> 5 subtractions
    rem_m_d = snap_q ? (bad_m ? 6'd0 : sel_m) : sub_m ? rem_m_q - 6'd10 : rem_m_q;
    rem_h_d = snap_q ? (bad_h ? 5'd0 : sel_h) : sub_h ? rem_h_q - 5'd10 : rem_h_q;
    ten_m_d = snap_q ? 4'd0 : sub_m ? ten_m_q + 4'd1 : ten_m_q;
    ten_h_d = snap_q ? 4'd0 : sub_h ? ten_h_q + 4'd1 : ten_h_q;
    disp_d  = done ? {inv_h_q, inv_m_q, ten_h_q, rem_h_q[3:0], ten_m_q, rem_m_q[3:0]} : disp_q;
    an_d    = off ? 4'hf : ~(4'b0001 << idx_q);
    seg_d   = off ? 7'h7f : dash ? 7'b0111111 : lz ? 7'h7f : code;
    dp_d    = off | idx_q != 2'd2 | ~(sa_q | phase_q);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_q   <= '0;
      blink_q <= '0;
      idx_q   <= 2'd0;
      phase_q <= 1'b0;
      snap_q  <= 1'b1;
      busy_q  <= 1'b0;
      sa_q    <= 1'b0;
      inv_m_q <= 1'b0;
      inv_h_q <= 1'b0;
      rem_m_q <= 6'd0;
      rem_h_q <= 5'd0;
      ten_m_q <= 4'd0;
      ten_h_q <= 4'd0;
      disp_q  <= 18'd0;
      an_q    <= 4'hf;
      seg_q   <= 7'h7f;
      dp_q    <= 1'b1;
    end else begin
      ref_q   <= ref_d;
      blink_q <= blink_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      snap_q  <= snap_d;
      busy_q  <= busy_d;
      sa_q    <= sa_d;
      inv_m_q <= inv_m_d;
      inv_h_q <= inv_h_d;
      rem_m_q <= rem_m_d;
      rem_h_q <= rem_h_d;
      ten_m_q <= ten_m_d;
      ten_h_q <= ten_h_d;
      disp_q  <= disp_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end
  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;
endmodule

// File: tb/tb_seg7_time_display.sv
// tb_seg7_time_display: scoreboard bench for the multiplexed HH:MM display (REFRESH_DIV=8, BLINK_DIV=32)
module tb_seg7_time_display;
  typedef struct packed {int k; logic [3:0] an; logic [6:0] seg; logic dp;} smp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [5:0] minutes = 6'd34, alarm_minutes = 6'd0;
  logic [4:0] hours = 5'd12, alarm_hours = 5'd0;
  logic show_alarm = 1'b0, blank = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic dp;
  smp_t exp_q[$], obs_q[$];
  int compared = 0, mismatched = 0, cyc = 0;

  seg7_time_display #(.REFRESH_DIV(8), .BLINK_DIV(32)) dut (
    .clk(clk), .rst(rst), .minutes(minutes), .hours(hours),
    .alarm_minutes(alarm_minutes), .alarm_hours(alarm_hours),
    .show_alarm(show_alarm), .blank(blank), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;
  // cyc = number of rising edges since reset release
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // expected outputs after edge k: edges 8j are anti-ghost blanks, others light digit ((k-1)/8)%4
  function automatic smp_t model(input int k, input int m, input int h, input logic sa, input logic blk);
    smp_t r;
    int idx, d;
    logic inv;
    r.k = k;
    r.an = 4'hf;
    r.seg = 7'h7f;
    r.dp = 1'b1;
    if (blk || k % 8 == 0) return r;
    idx = ((k - 1) / 8) % 4;
    inv = (idx < 2) ? (m > 59) : (h > 23);
    d = (idx == 0) ? m % 10 : (idx == 1) ? m / 10 : (idx == 2) ? h % 10 : h / 10;
    r.an[idx] = 1'b0;
    r.seg = inv ? 7'b0111111 : (idx == 3 && d == 0) ? 7'h7f : seg_of(d);
    r.dp = !(idx == 2 && (sa || ((k - 1) / 32) % 2 == 1));
    return r;
  endfunction

  function automatic int next_snap(input int c);
    int s = (c / 32) * 32 + 1;
    return (s > c) ? s : s + 32;
  endfunction

  task automatic wait_cyc(input int t);
    for (int g = 0; cyc < t; g++) begin
      if (g > 5000) begin
        $display("FAIL wait_cyc target=%0d stuck at cyc=%0d", t, cyc);
        $fatal(1);
      end
      @(negedge clk);
    end
  endtask

  task automatic push_exp(input int m, input int h, input logic sa, input int k0, input int n, input int b0, input int b1);
    for (int i = 0; i < n; i++) exp_q.push_back(model(k0 + i, m, h, sa, (k0 + i >= b0) && (k0 + i <= b1)));
  endtask

  task automatic capture(input int k0, input int n);
    smp_t s;
    wait_cyc(k0);
    for (int i = 0; i < n; i++) begin
      s.k = cyc;
      s.an = an;
      s.seg = seg;
      s.dp = dp;
      obs_q.push_back(s);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if (an !== 4'hf) begin mismatched++; $display("FAIL reset_an got %b want 1111", an); end
    compared++;
    if (seg !== 7'h7f) begin mismatched++; $display("FAIL reset_seg got %b want 1111111", seg); end
    compared++;
    if (dp !== 1'b1) begin mismatched++; $display("FAIL reset_dp got %b want 1", dp); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    smp_t e, o;
    push_exp(34, 12, 1'b0, 9, 88, -1, -1);
    capture(9, 88);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = '0;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      compared++;
      if (o !== e) begin
        mismatched++;
        $display("FAIL basic k=%0d got an=%b seg=%b dp=%b (k=%0d) want an=%b seg=%b dp=%b", e.k, o.an, o.seg, o.dp, o.k, e.an, e.seg, e.dp);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_digit_patterns();
    int tm[4] = '{7, 0, 60, 60};
    int th[4] = '{5, 0, 10, 24};
    int k0;
    smp_t e, o;
    for (int i = 0; i < 4; i++) begin
      minutes = 6'(tm[i]);
      hours = 5'(th[i]);
      k0 = next_snap(cyc) + 32;
      push_exp(tm[i], th[i], 1'b0, k0, 32, -1, -1);
      capture(k0, 32);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        o = '0;
        if (obs_q.size() > 0) o = obs_q.pop_front();
        compared++;
        if (o !== e) begin
          mismatched++;
          $display("FAIL digits_%0d k=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", i, e.k, o.an, o.seg, o.dp, e.an, e.seg, e.dp);
        end
      end
      obs_q.delete();
    end
  endtask

  task automatic test_conversion();
    int s;
    smp_t e, o;
    minutes = 6'd59;
    hours = 5'd23;
    s = next_snap(cyc);
    push_exp(59, 23, 1'b0, s + 7, 25, -1, -1);
    push_exp(0, 23, 1'b0, s + 64, 32, -1, -1);
    fork
      capture(s + 7, 25);
      begin wait_cyc(s + 12); minutes = 6'd0; end
    join
    capture(s + 64, 32);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = '0;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      compared++;
      if (o !== e) begin
        mismatched++;
        $display("FAIL conversion k=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", e.k, o.an, o.seg, o.dp, e.an, e.seg, e.dp);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_alarm();
    int k0;
    smp_t e, o;
    minutes = 6'd11;
    hours = 5'd11;
    alarm_minutes = 6'd45;
    alarm_hours = 5'd6;
    show_alarm = 1'b1;
    k0 = next_snap(cyc) + 32;
    push_exp(45, 6, 1'b1, k0, 64, -1, -1);
    capture(k0, 64);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = '0;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      compared++;
      if (o !== e) begin
        mismatched++;
        $display("FAIL alarm k=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", e.k, o.an, o.seg, o.dp, e.an, e.seg, e.dp);
      end
    end
    obs_q.delete();
    show_alarm = 1'b0;
  endtask

  task automatic test_blank();
    int k0;
    smp_t e, o;
    minutes = 6'd34;
    hours = 5'd12;
    k0 = next_snap(cyc) + 32;
    push_exp(34, 12, 1'b0, k0, 32, k0 + 4, k0 + 23);
    fork
      capture(k0, 32);
      begin wait_cyc(k0 + 3); blank = 1'b1; wait_cyc(k0 + 23); blank = 1'b0; end
    join
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = '0;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      compared++;
      if (o !== e) begin
        mismatched++;
        $display("FAIL blank k=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", e.k, o.an, o.seg, o.dp, e.an, e.seg, e.dp);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_rst_mid();
    int s;
    smp_t e, o;
    minutes = 6'd59;
    hours = 5'd23;
    s = next_snap(cyc);
    wait_cyc(s);
    rst = 1'b1;
    #1;
    compared++;
    if (an !== 4'hf) begin mismatched++; $display("FAIL rst_mid_an got %b want 1111", an); end
    compared++;
    if (seg !== 7'h7f) begin mismatched++; $display("FAIL rst_mid_seg got %b want 1111111", seg); end
    compared++;
    if (dp !== 1'b1) begin mismatched++; $display("FAIL rst_mid_dp got %b want 1", dp); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_exp(59, 23, 1'b0, 9, 56, -1, -1);
    capture(9, 56);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = '0;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      compared++;
      if (o !== e) begin
        mismatched++;
        $display("FAIL after_rst k=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", e.k, o.an, o.seg, o.dp, e.an, e.seg, e.dp);
      end
    end
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_digit_patterns();
    test_conversion();
    test_alarm();
    test_blank();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
